// File: rtl/common_ram_stream_reader.sv
// Streams LENGTH consecutive RAM words from BASE_ADDR as a valid/ready burst.
// Credit-limited 4-deep buffer absorbs the fixed RAM read latency.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start/base_addr/length command strobe and fields (sampled in IDLE)
//   busy, done            command in progress / one-cycle completion pulse
//   ram_re/ram_raddr/ram_rdata  RAM read port
//   m_valid/m_ready/m_data/m_last  output stream
module common_ram_stream_reader #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter int    LEN_WIDTH  = 10,
  parameter string OUTPUT_REG = "TRUE"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int RD_LAT = (OUTPUT_REG == "TRUE") ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0]     pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0] mem_q [4];
  logic [DATA_WIDTH-1:0] mem_d [4];
  logic [1:0]            wr_q, wr_d;
  logic [1:0]            rd_q, rd_d;
  logic [2:0]            cnt_q, cnt_d;

  logic [2:0] in_flight;
  logic       push;
  logic       pop;

  // Reads already issued but not yet landed in the buffer.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + 3'(pipe_q[i]);
    end
  end

  // Credit check uses pre-pop occupancy, so a landing word always has a slot.
  assign ram_re = (state_q == S_RUN) && (rem_q != '0)
                  && ((in_flight + cnt_q) < 3'd4);
  assign ram_raddr = addr_q;

  assign push    = pipe_q[RD_LAT-1];
  assign m_valid = (cnt_q != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? mem_q[rd_q] : '0;
  assign m_last  = m_valid && (beat_q == (len_q - LEN_WIDTH'(1)));

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    len_d   = len_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    pipe_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = length;
          rem_d   = length;
          addr_d  = base_addr;
          beat_d  = '0;
          state_d = (length != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (ram_re) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pipe_d[0] = ram_re;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (push) begin
      mem_d[wr_q] = ram_rdata;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) begin
      rd_d   = rd_q + 2'd1;
      beat_d = beat_q + LEN_WIDTH'(1);
    end
    cnt_d = cnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      pipe_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      pipe_q  <= pipe_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_common_ram_stream_reader.sv
// Bench: two readers (2-cycle and 1-cycle RAM) share one stimulus stream;
// a scoreboard checks every beat, address, latency and done pulse.
module tb_common_ram_stream_reader;

  typedef logic [8:0] beat_t;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic [8:0] base_addr = '0;
  logic [9:0] length = '0;
  logic       m_ready = 0;

  logic [1:0] busy, done, re, mv, ml;
  logic [8:0] raddr [2];
  logic [7:0] rdata [2];
  logic [7:0] mdata [2];

  logic [7:0] mem [512];
  logic [7:0] stage_a;
  int         cyc = 0;
  int         rmode = 0;

  int total = 0;
  int bad = 0;

  beat_t q0 [$];
  beat_t q1 [$];

  int start_cyc [2];
  int done_cyc [2];
  int cmd_len [2];
  int reads_cmd [2];
  int exp_addr [2];
  int issued [2];
  int popped [2];
  int done_cnt [2];
  int tgt [2];
  int held [2];
  bit held_v [2];
  bit first_pend [2];

  common_ram_stream_reader #(.OUTPUT_REG("TRUE")) dut_a (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy[0]), .done(done[0]), .ram_re(re[0]),
    .ram_raddr(raddr[0]), .ram_rdata(rdata[0]), .m_valid(mv[0]),
    .m_ready(m_ready), .m_data(mdata[0]), .m_last(ml[0])
  );

  common_ram_stream_reader #(.OUTPUT_REG("FALSE")) dut_b (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy[1]), .done(done[1]), .ram_re(re[1]),
    .ram_raddr(raddr[1]), .ram_rdata(rdata[1]), .m_valid(mv[1]),
    .m_ready(m_ready), .m_data(mdata[1]), .m_last(ml[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM read ports: registered-output (2 cycles) and plain (1 cycle).
  always @(posedge clk) begin
    if (re[0]) stage_a <= mem[raddr[0]];
    rdata[0] <= stage_a;
    if (re[1]) rdata[1] <= mem[raddr[1]];
  end

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input int k,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h",
               nm, k, cyc, act, exp);
    end
  endtask

  task automatic mon(input int k);
    beat_t e;
    int    sz;
    if (rst) begin
      held_v[k] = 0;
      return;
    end
    if (re[k]) begin
      chk("raddr", k, int'(raddr[k]), exp_addr[k]);
      exp_addr[k] = (exp_addr[k] + 1) % 512;
      issued[k]++;
      reads_cmd[k]++;
      chk("credit", k, int'(issued[k] - popped[k] <= 4), 1);
      chk("nreads_live", k, int'(reads_cmd[k] <= cmd_len[k]), 1);
    end
    if (mv[k]) begin
      if (first_pend[k]) begin
        chk("latency", k, cyc - start_cyc[k], 2 + lat(k));
        first_pend[k] = 0;
      end
      if (held_v[k]) chk("stable", k, int'({ml[k], mdata[k]}), held[k]);
      if (m_ready) begin
        sz = (k == 0) ? q0.size() : q1.size();
        chk("extra_beat", k, int'(sz > 0), 1);
        if (sz > 0) begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk("beat", k, int'({ml[k], mdata[k]}), int'(e));
        end
        popped[k]++;
        held_v[k] = 0;
        if (ml[k]) done_cyc[k] = cyc + 1;
      end else begin
        held_v[k] = 1;
        held[k]   = int'({ml[k], mdata[k]});
      end
    end else begin
      held_v[k] = 0;
    end
    if (done[k] || cyc == done_cyc[k]) begin
      chk("done", k, int'(done[k]), int'(cyc == done_cyc[k]));
      if (done[k]) begin
        done_cnt[k]++;
        chk("nreads", k, reads_cmd[k], cmd_len[k]);
        chk("busy_at_done", k, int'(busy[k]), 0);
      end
    end
  endtask

  // Called at posedge+1 with both readers idle.
  task automatic issue(input int b, input int l);
    beat_t e;
    start     = 1;
    base_addr = 9'(b);
    length    = 10'(l);
    for (int k = 0; k < 2; k++) begin
      start_cyc[k]  = cyc;
      cmd_len[k]    = l;
      reads_cmd[k]  = 0;
      exp_addr[k]   = b % 512;
      first_pend[k] = (l != 0);
      tgt[k]        = done_cnt[k] + 1;
      if (l == 0) done_cyc[k] = cyc + 1;
    end
    for (int i = 0; i < l; i++) begin
      e = {(i == l - 1), mem[(b + i) % 512]};
      q0.push_back(e);
      q1.push_back(e);
    end
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done();
    int w = 0;
    do begin
      @(posedge clk);
      #1;
      w++;
    end while ((done_cnt[0] < tgt[0] || done_cnt[1] < tgt[1]) && w < 3000);
    chk("finish", 0, int'(w < 3000), 1);
  endtask

  task automatic clear_sb();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      first_pend[k] = 0;
      done_cyc[k]   = -10;
      issued[k]     = 0;
      popped[k]     = 0;
      reads_cmd[k]  = 0;
      cmd_len[k]    = 0;
      held_v[k]     = 0;
    end
  endtask

  task automatic chk_quiet(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk(nm, k, int'({busy[k], done[k], re[k], mv[k], ml[k],
                       raddr[k], mdata[k]}), 0);
    end
  endtask

  initial begin
    int n;
    int w;
    for (int a = 0; a < 512; a++) mem[a] = 8'(a);
    for (int k = 0; k < 2; k++) done_cnt[k] = 0;
    clear_sb();

    fork
      forever begin
        @(negedge clk);
        mon(0);
        mon(1);
      end
      forever begin
        @(posedge clk);
        #1;
        case (rmode)
          0: m_ready = 1;
          1: m_ready = ~m_ready;
          2: m_ready = 1'($urandom_range(0, 1));
          default: m_ready = 0;
        endcase
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_quiet("reset_state");
    @(posedge clk);
    #1;

    // Basic burst, plus an ignored start while busy.
    rmode = 0;
    issue(9'h010, 4);
    repeat (2) @(posedge clk);
    #1 start = 1;
    base_addr = 9'h100;
    length    = 10'd5;
    @(posedge clk);
    #1 start = 0;
    wait_done();

    // Toggling backpressure.
    rmode = 1;
    issue(0, 8);
    wait_done();

    // Address wrap.
    rmode = 0;
    issue(9'h1FE, 4);
    wait_done();

    // Empty command.
    issue(9'h055, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("len0_quiet", k, int'({busy[k], re[k], mv[k]}), 0);
      end
    end
    wait_done();

    // Reset in the middle of a stalled command.
    rmode = 3;
    issue(0, 8);
    n = 0;
    w = 0;
    while (n < 3 && w < 100) begin
      @(negedge clk);
      if (re[0]) n++;
      w++;
    end
    chk("reads_before_rst", 0, n, 3);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    clear_sb();
    @(negedge clk);
    chk_quiet("after_rst");
    @(posedge clk);
    #1 rmode = 0;
    issue(9'h040, 2);
    wait_done();

    // Randomized commands over random RAM contents.
    for (int a = 0; a < 512; a++) mem[a] = 8'($urandom);
    for (int t = 0; t < 30; t++) begin
      rmode = (t % 3 == 0) ? 0 : 2;
      issue(int'($urandom_range(0, 511)),
            (t % 7 == 0) ? int'($urandom_range(0, 1))
                         : int'($urandom_range(2, 40)));
      wait_done();
    end

    chk("q_empty", 0, q0.size(), 0);
    chk("q_empty", 1, q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
